// File: rtl/chimera_fixture_pkg.sv
// Shared constants, request/response structs and boot-mode encoding for the
// Chimera preload/EOC harness.
package chimera_fixture_pkg;

  localparam int unsigned NumPorts       = 2;
  localparam int unsigned DataW          = 32;
  localparam logic [31:0] DefMemBaseAddr = 32'h4800_0000;
  localparam int unsigned DefMemNumWords = 8192;
  localparam logic [31:0] DefEocAddr     = 32'h0300_0008;
  localparam logic [31:0] DefErrData     = 32'hBADC_AB1E;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } narrow_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } narrow_rsp_t;

  typedef enum logic [1:0] {
    BOOT_IDLE = 2'd0,
    BOOT_SD   = 2'd1,
    BOOT_SPI  = 2'd2,
    BOOT_I2C  = 2'd3
  } boot_mode_e;

endpackage

// File: rtl/chimera_fixture_if.sv
// Two-port narrow memory bus: port 0 is the core, port 1 the ELF preloader.
interface chimera_fixture_if;
  import chimera_fixture_pkg::*;

  logic [NumPorts-1:0]            narrow_req_i;
  logic [NumPorts-1:0]            narrow_we_i;
  logic [NumPorts-1:0][DataW-1:0] narrow_addr_i;
  logic [NumPorts-1:0][DataW-1:0] narrow_wdata_i;
  logic [NumPorts-1:0][3:0]       narrow_strb_i;
  logic [NumPorts-1:0]            narrow_gnt_o;
  logic [NumPorts-1:0]            narrow_rvalid_o;
  logic [NumPorts-1:0][DataW-1:0] narrow_rdata_o;

  modport master (
    output narrow_req_i, narrow_we_i, narrow_addr_i, narrow_wdata_i, narrow_strb_i,
    input  narrow_gnt_o, narrow_rvalid_o, narrow_rdata_o
  );

  modport slave (
    input  narrow_req_i, narrow_we_i, narrow_addr_i, narrow_wdata_i, narrow_strb_i,
    output narrow_gnt_o, narrow_rvalid_o, narrow_rdata_o
  );

endinterface

// File: rtl/chimera_fixture_sram.sv
// Byte-strobed single-port word array; read data (old word) appears one cycle
// after the enable. Contents and read register are intentionally unreset.
module chimera_fixture_sram #(
  parameter  int unsigned NumWords = 8192,
  localparam int unsigned AW       = $clog2(NumWords)
) (
  input  logic          clk_i,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    strb,
  output logic [31:0]   rdata
);

  logic [31:0] mem [NumWords];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/chimera_soc_fixture.sv
// Chimera SoC preload/EOC harness: two-port arbitration onto one memory bank,
// address decode, Cheshire-style EOC register, hart halt/resume and boot latch.
module chimera_soc_fixture
  import chimera_fixture_pkg::*;
#(
  parameter logic [31:0] MemBaseAddr = DefMemBaseAddr,
  parameter int unsigned MemNumWords = DefMemNumWords,
  parameter logic [31:0] EocAddr     = DefEocAddr,
  parameter logic [31:0] ErrData     = DefErrData
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [1:0]         boot_mode_i,
  output logic [1:0]         boot_mode_o,
  output logic               boot_err_o,
  input  logic               halt_req_i,
  input  logic               resume_req_i,
  output logic               halted_o,
  chimera_fixture_if.slave   narrow,
  output logic               eoc_valid_o,
  output logic [31:0]        exit_code_o
);

  localparam int unsigned AW      = $clog2(MemNumWords);
  localparam logic [32:0] MemSpan = 33'(MemNumWords) * 33'd4;

  narrow_req_t [NumPorts-1:0] req;
  narrow_rsp_t [NumPorts-1:0] rsp;
  logic        [NumPorts-1:0] gnt;
  logic        [NumPorts-1:0] rvalid_q;
  narrow_req_t                sel;
  logic                       sel_port;
  logic                       access;
  logic [31:0]                offset;
  logic                       in_mem;
  logic                       is_eoc;
  logic [31:0]                sram_rdata;
  logic                       src_mem_q;
  logic [31:0]                side_q;
  logic [31:0]                live_rdata;
  logic                       boot_done;

  // Grant is combinational; reset forces it low so nothing can be written
  // into the bank while rst_ni is asserted.
  assign gnt[1] = req[1].req & rst_ni;
  assign gnt[0] = req[0].req & ~req[1].req & ~halted_o & rst_ni;

  assign sel_port = gnt[1];
  assign sel      = req[sel_port];
  assign access   = sel.req & (|gnt);
  assign offset   = sel.addr - MemBaseAddr;
  assign in_mem   = (sel.addr >= MemBaseAddr) && ({1'b0, offset} < MemSpan);
  assign is_eoc   = ~sel_port && (sel.addr == EocAddr);

  chimera_fixture_sram #(.NumWords(MemNumWords)) i_sram (
    .clk_i (clk_i),
    .en    (access & in_mem),
    .we    (sel.we),
    .idx   (offset[AW+1:2]),
    .wdata (sel.wdata),
    .strb  (sel.strb),
    .rdata (sram_rdata)
  );

  // Only one port is granted per cycle, so the response source is shared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q  <= '0;
      src_mem_q <= 1'b0;
      side_q    <= '0;
    end else begin
      rvalid_q <= gnt;
      if (access) begin
        src_mem_q <= in_mem;
        side_q    <= is_eoc ? {exit_code_o[30:0], eoc_valid_o} : ErrData;
      end
    end
  end

  assign live_rdata = src_mem_q ? sram_rdata : side_q;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic [31:0] hold_q;

    assign req[p] = '{req:   narrow.narrow_req_i[p],
                      we:    narrow.narrow_we_i[p],
                      addr:  narrow.narrow_addr_i[p],
                      wdata: narrow.narrow_wdata_i[p],
                      strb:  narrow.narrow_strb_i[p]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          hold_q <= '0;
      else if (rvalid_q[p]) hold_q <= live_rdata;
    end

    assign rsp[p].gnt    = gnt[p];
    assign rsp[p].rvalid = rvalid_q[p];
    assign rsp[p].rdata  = rvalid_q[p] ? live_rdata : hold_q;

    assign narrow.narrow_gnt_o[p]    = rsp[p].gnt;
    assign narrow.narrow_rvalid_o[p] = rsp[p].rvalid;
    assign narrow.narrow_rdata_o[p]  = rsp[p].rdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eoc_valid_o <= 1'b0;
      exit_code_o <= '0;
    end else if (access && is_eoc && sel.we && sel.wdata[0]) begin
      eoc_valid_o <= 1'b1;
      exit_code_o <= {1'b0, sel.wdata[31:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           halted_o <= 1'b0;
    else if (halt_req_i)   halted_o <= 1'b1;
    else if (resume_req_i) halted_o <= 1'b0;
  end

  // Straps are sampled once, on the first edge out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_done   <= 1'b0;
      boot_mode_o <= 2'd0;
      boot_err_o  <= 1'b0;
    end else if (!boot_done) begin
      boot_done   <= 1'b1;
      boot_mode_o <= boot_mode_i;
      boot_err_o  <= (boot_mode_e'(boot_mode_i) == BOOT_SD);
    end
  end

endmodule

// File: tb/tb_chimera_soc_fixture.sv
// Self-checking bench for chimera_soc_fixture: directed table, hand-written
// multi-cycle sequences and randomized accesses against a word-map model.
module tb_chimera_soc_fixture;
  import chimera_fixture_pkg::*;

  localparam logic [31:0] BASE = 32'h4800_0000;
  localparam logic [31:0] EOC  = 32'h0300_0008;
  localparam logic [31:0] ERR  = 32'hBADC_AB1E;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [1:0]  boot_mode_i;
  logic [1:0]  boot_mode_o;
  logic        boot_err_o;
  logic        halt_req_i, resume_req_i, halted_o;
  logic        eoc_valid_o;
  logic [31:0] exit_code_o;

  chimera_fixture_if bus ();

  chimera_soc_fixture dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .boot_mode_i  (boot_mode_i),
    .boot_mode_o  (boot_mode_o),
    .boot_err_o   (boot_err_o),
    .halt_req_i   (halt_req_i),
    .resume_req_i (resume_req_i),
    .halted_o     (halted_o),
    .narrow       (bus),
    .eoc_valid_o  (eoc_valid_o),
    .exit_code_o  (exit_code_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit [31:0] mdl [int];
  bit        m_eoc;
  bit [31:0] m_exit;

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit mapped(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h8000);
  endfunction

  function automatic void mdl_apply(input int p, input bit we, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] st);
    if (!we) return;
    if (mapped(a)) begin
      int w = int'((a - BASE) >> 2);
      bit [31:0] o = mdl.exists(w) ? mdl[w] : 32'h0;
      for (int b = 0; b < 4; b++) if (st[b]) o[8*b +: 8] = wd[8*b +: 8];
      mdl[w] = o;
    end else if (p == 0 && a == EOC && wd[0]) begin
      m_eoc  = 1'b1;
      m_exit = wd >> 1;
    end
  endfunction

  function automatic logic [31:0] mdl_read(input int p, input logic [31:0] a);
    if (p == 0 && a == EOC) return {m_exit[30:0], m_eoc};
    if (mapped(a)) return mdl[int'((a - BASE) >> 2)];
    return ERR;
  endfunction

  task automatic idle_bus();
    bus.narrow_req_i   = '0;
    bus.narrow_we_i    = '0;
    bus.narrow_addr_i  = '0;
    bus.narrow_wdata_i = '0;
    bus.narrow_strb_i  = '0;
  endtask

  task automatic drive(input int p, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    bus.narrow_req_i[p]   = 1'b1;
    bus.narrow_we_i[p]    = we;
    bus.narrow_addr_i[p]  = a;
    bus.narrow_wdata_i[p] = wd;
    bus.narrow_strb_i[p]  = st;
  endtask

  // Single access starting at a negedge; returns at the next negedge.
  task automatic access(input int p, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic g, output logic rv);
    drive(p, we, a, wd, st);
    #1 g = bus.narrow_gnt_o[p];
    @(posedge clk); #1;
    rv = bus.narrow_rvalid_o[p];
    rd = bus.narrow_rdata_o[p];
    bus.narrow_req_i[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic op(input string nm, input int p, input bit we, input logic [31:0] a,
                    input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] rd, exp;
    logic g, rv;
    exp = mdl_read(p, a);
    access(p, we, a, wd, st, rd, g, rv);
    mdl_apply(p, we, a, wd, st);
    chk({nm, ".gnt"}, {31'd0, g}, 32'd1);
    chk({nm, ".rvalid"}, {31'd0, rv}, 32'd1);
    if (!we) chk({nm, ".rdata"}, rd, exp);
    chk({nm, ".eoc"}, {31'd0, eoc_valid_o}, {31'd0, m_eoc});
    chk({nm, ".exit"}, exit_code_o, m_exit);
  endtask

  task automatic do_reset(input logic [1:0] bm);
    @(negedge clk);
    rst_ni = 1'b0;
    boot_mode_i = bm;
    halt_req_i = 1'b0;
    resume_req_i = 1'b0;
    idle_bus();
    m_eoc = 1'b0;
    m_exit = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic g, rv;
    rst_ni = 1'b0;
    boot_mode_i = 2'd2;
    halt_req_i = 1'b0;
    resume_req_i = 1'b0;
    idle_bus();
    m_eoc = 1'b0;
    m_exit = '0;

    // 1. reset state and boot latch
    #1;
    chk("rst.halted", {31'd0, halted_o}, 32'd0);
    chk("rst.boot", {30'd0, boot_mode_o}, 32'd0);
    chk("rst.rvalid", {30'd0, bus.narrow_rvalid_o}, 32'd0);
    chk("rst.rdata0", bus.narrow_rdata_o[0], 32'd0);
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); @(negedge clk);
    boot_mode_i = 2'd1;
    chk("boot.mode", {30'd0, boot_mode_o}, 32'd2);
    chk("boot.err", {31'd0, boot_err_o}, 32'd0);
    chk("boot.eoc", {31'd0, eoc_valid_o}, 32'd0);
    chk("boot.exit", exit_code_o, 32'd0);
    chk("boot.gnt", {30'd0, bus.narrow_gnt_o}, 32'd0);
    chk("boot.rdata1", bus.narrow_rdata_o[1], 32'd0);
    @(negedge clk);
    chk("boot.hold", {30'd0, boot_mode_o}, 32'd2);

    // 2. halt, then back-to-back preload writes on port 1
    halt_req_i = 1'b1;
    @(negedge clk);
    halt_req_i = 1'b0;
    chk("halt.set", {31'd0, halted_o}, 32'd1);
    drive(1, 1'b1, BASE, 32'hDEADBEEF, 4'hf);
    #1 chk("pre.gnt_a", {31'd0, bus.narrow_gnt_o[1]}, 32'd1);
    @(negedge clk);
    chk("pre.rv_a", {31'd0, bus.narrow_rvalid_o[1]}, 32'd1);
    drive(1, 1'b1, BASE + 4, 32'h12345678, 4'hf);
    #1 chk("pre.gnt_b", {31'd0, bus.narrow_gnt_o[1]}, 32'd1);
    @(negedge clk);
    chk("pre.rv_b", {31'd0, bus.narrow_rvalid_o[1]}, 32'd1);
    bus.narrow_req_i[1] = 1'b0;
    mdl_apply(1, 1'b1, BASE, 32'hDEADBEEF, 4'hf);
    mdl_apply(1, 1'b1, BASE + 4, 32'h12345678, 4'hf);
    @(negedge clk);

    // 3. port 0 stalls while halted, granted after resume; port 1 priority
    drive(0, 1'b0, BASE, 32'h0, 4'h0);
    #1 chk("stall.gnt0_a", {31'd0, bus.narrow_gnt_o[0]}, 32'd0);
    @(negedge clk);
    chk("stall.gnt0_b", {31'd0, bus.narrow_gnt_o[0]}, 32'd0);
    chk("stall.rv0", {31'd0, bus.narrow_rvalid_o[0]}, 32'd0);
    resume_req_i = 1'b1;
    #1 chk("resume.gnt0_pre", {31'd0, bus.narrow_gnt_o[0]}, 32'd0);
    @(posedge clk); #1;
    resume_req_i = 1'b0;
    chk("resume.halted", {31'd0, halted_o}, 32'd0);
    chk("resume.gnt0", {31'd0, bus.narrow_gnt_o[0]}, 32'd1);
    @(posedge clk); #1;
    chk("resume.rv0", {31'd0, bus.narrow_rvalid_o[0]}, 32'd1);
    chk("resume.rd0", bus.narrow_rdata_o[0], 32'hDEADBEEF);
    bus.narrow_req_i[0] = 1'b0;
    @(negedge clk);
    drive(0, 1'b0, BASE + 4, 32'h0, 4'h0);
    drive(1, 1'b0, BASE, 32'h0, 4'h0);
    #1 chk("both.gnt", {30'd0, bus.narrow_gnt_o}, 32'd2);
    @(posedge clk); #1;
    chk("both.rv", {30'd0, bus.narrow_rvalid_o}, 32'd2);
    chk("both.rd1", bus.narrow_rdata_o[1], 32'hDEADBEEF);
    bus.narrow_req_i[1] = 1'b0;
    #1 chk("both.gnt0_late", {30'd0, bus.narrow_gnt_o}, 32'd1);
    @(posedge clk); #1;
    chk("both.rv_late", {30'd0, bus.narrow_rvalid_o}, 32'd1);
    chk("both.rd0", bus.narrow_rdata_o[0], 32'h12345678);
    chk("both.rd1_hold", bus.narrow_rdata_o[1], 32'hDEADBEEF);
    bus.narrow_req_i[0] = 1'b0;
    @(negedge clk);
    halt_req_i = 1'b1; resume_req_i = 1'b1;
    @(negedge clk);
    halt_req_i = 1'b0; resume_req_i = 1'b0;
    chk("halt.wins", {31'd0, halted_o}, 32'd1);
    resume_req_i = 1'b1;
    @(negedge clk);
    resume_req_i = 1'b0;
    chk("halt.cleared", {31'd0, halted_o}, 32'd0);

    // 4. directed table: strobes, boundaries, unmapped accesses
    tbl.push_back('{0, 1'b0, BASE,            32'h0,        4'h0, 32'hDEADBEEF});
    tbl.push_back('{0, 1'b0, BASE + 4,        32'h0,        4'h0, 32'h12345678});
    tbl.push_back('{0, 1'b1, BASE + 32'h10,   32'h0,        4'hf, 32'h0});
    tbl.push_back('{0, 1'b1, BASE + 32'h10,   32'hAABBCCDD, 4'h5, 32'h0});
    tbl.push_back('{0, 1'b0, BASE + 32'h10,   32'h0,        4'h0, 32'h00BB00DD});
    tbl.push_back('{1, 1'b0, BASE + 32'h13,   32'h0,        4'h0, 32'h00BB00DD});
    tbl.push_back('{0, 1'b0, 32'h5000_0000,   32'h0,        4'h0, 32'hBADCAB1E});
    tbl.push_back('{1, 1'b1, BASE + 32'h7FFC, 32'h0BADF00D, 4'hf, 32'h0});
    tbl.push_back('{0, 1'b0, BASE + 32'h7FFC, 32'h0,        4'h0, 32'h0BADF00D});
    tbl.push_back('{0, 1'b0, BASE + 32'h8000, 32'h0,        4'h0, 32'hBADCAB1E});
    tbl.push_back('{1, 1'b0, 32'h47FF_FFFC,   32'h0,        4'h0, 32'hBADCAB1E});
    tbl.push_back('{1, 1'b0, EOC,             32'h0,        4'h0, 32'hBADCAB1E});
    tbl.push_back('{0, 1'b1, BASE + 32'h10,   32'h11223344, 4'hA, 32'h0});
    tbl.push_back('{1, 1'b0, BASE + 32'h10,   32'h0,        4'h0, 32'h11BB33DD});
    foreach (tbl[i]) begin
      access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, g, rv);
      mdl_apply(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb);
      chk($sformatf("tbl%0d.gnt", i), {31'd0, g}, 32'd1);
      chk($sformatf("tbl%0d.rv", i), {31'd0, rv}, 32'd1);
      if (!tbl[i].we) chk($sformatf("tbl%0d.rd", i), rd, tbl[i].exp);
    end

    // 5. EOC register
    op("eoc.w0", 0, 1'b1, EOC, 32'h0, 4'hf);
    chk("eoc.stays0", {31'd0, eoc_valid_o}, 32'd0);
    op("eoc.r0", 0, 1'b0, EOC, 32'h0, 4'h0);
    op("eoc.w1", 0, 1'b1, EOC, 32'h1, 4'hf);
    chk("eoc.set", {31'd0, eoc_valid_o}, 32'd1);
    chk("eoc.code0", exit_code_o, 32'd0);
    op("eoc.p1drop", 1, 1'b1, EOC, 32'hFF, 4'hf);
    op("eoc.r1", 0, 1'b0, EOC, 32'h0, 4'h0);
    op("eoc.wnop", 0, 1'b1, EOC, 32'h10, 4'hf);
    do_reset(2'd2);
    chk("fresh.eoc", {31'd0, eoc_valid_o}, 32'd0);
    op("fresh.w7", 0, 1'b1, EOC, 32'h7, 4'hf);
    chk("fresh.code3", exit_code_o, 32'd3);
    op("fresh.r7", 0, 1'b0, EOC, 32'h0, 4'h0);
    op("fresh.memkeep", 0, 1'b0, BASE, 32'h0, 4'h0);

    // randomized accesses against the word-map model
    for (int w = 0; w < 16; w++)
      op("rnd.init", int'($urandom_range(0, 1)), 1'b1, BASE + 32'h100 + 32'(w * 4), $urandom, 4'hf);
    for (int n = 0; n < 150; n++) begin
      int p = int'($urandom_range(0, 1));
      int k = int'($urandom_range(0, 9));
      bit we = 1'($urandom_range(0, 1));
      logic [31:0] a;
      if (k < 8)       a = BASE + 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      else if (k == 8) a = 32'h6000_0000 + ($urandom & 32'hFFFC);
      else             a = EOC;
      op($sformatf("rnd%0d", n), p, we, a, $urandom, 4'($urandom_range(0, 15)));
    end

    // 6. reset mid-operation
    drive(0, 1'b1, BASE, 32'h5555_5555, 4'hf);
    #1 chk("mid.gnt", {31'd0, bus.narrow_gnt_o[0]}, 32'd1);
    rst_ni = 1'b0;
    boot_mode_i = 2'd3;
    m_eoc = 1'b0; m_exit = '0;
    #1 chk("mid.gnt_rst", {31'd0, bus.narrow_gnt_o[0]}, 32'd0);
    @(posedge clk); #1;
    chk("mid.rv", {31'd0, bus.narrow_rvalid_o[0]}, 32'd0);
    chk("mid.eoc", {31'd0, eoc_valid_o}, 32'd0);
    chk("mid.rd0", bus.narrow_rdata_o[0], 32'd0);
    idle_bus();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    chk("mid.boot", {30'd0, boot_mode_o}, 32'd3);
    chk("mid.err", {31'd0, boot_err_o}, 32'd0);
    @(negedge clk);
    op("mid.nowrite", 0, 1'b0, BASE, 32'h0, 4'h0);
    // reset falling while a response is in flight cancels it
    drive(1, 1'b0, BASE + 4, 32'h0, 4'h0);
    @(posedge clk); #1;
    chk("mid2.rv_pre", {31'd0, bus.narrow_rvalid_o[1]}, 32'd1);
    rst_ni = 1'b0;
    boot_mode_i = 2'd1;
    #1 chk("mid2.rv_cut", {31'd0, bus.narrow_rvalid_o[1]}, 32'd0);
    idle_bus();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    chk("err.boot", {30'd0, boot_mode_o}, 32'd1);
    chk("err.flag", {31'd0, boot_err_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout: got no finish want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chimera_soc_fixture.md
Name: chimera_soc_fixture

Overview:
Synthesizable harness model of the Chimera SoC preload/end-of-computation path. It provides:
- a single-bank word memory island with two 32-bit narrow ports: port 0 for the core/bus, port 1 for fast ELF preload;
- a hart halt/resume control;
- a latched boot mode;
- a Cheshire-style EOC register.

Testbench tasks drive preload writes on port 1 while the hart is halted, then resume it and poll the EOC/exit-code outputs.

Parameters:
- MemBaseAddr, 32'h4800_0000: byte base address of the memory island.
- MemNumWords, 8192: memory depth in 32-bit words (32 KiB).
- EocAddr, 32'h0300_0008: byte address of the EOC scratch register; must lie outside the memory range.
- ErrData, 32'hBADC_AB1E: read data returned for unmapped addresses.

Ports:
- clk_i in 1: SoC clock.
- rst_ni in 1: asynchronous active-low reset.
- boot_mode_i in 2: boot mode straps.
- boot_mode_o out 2: latched boot mode.
- boot_err_o out 1: unsupported boot mode (1) latched.
- halt_req_i in 1: debug halt request pulse.
- resume_req_i in 1: debug resume request pulse.
- halted_o out 1: hart halted.
- narrow_req_i in 2: per-port request.
- narrow_we_i in 2: per-port write enable.
- narrow_addr_i in 2x32: per-port byte address.
- narrow_wdata_i in 2x32: per-port write data.
- narrow_strb_i in 2x4: per-port byte strobes.
- narrow_gnt_o out 2: per-port grant.
- narrow_rvalid_o out 2: per-port response valid.
- narrow_rdata_o out 2x32: per-port read data.
- eoc_valid_o out 1: end of computation reached.
- exit_code_o out 32: program exit code.

Behaviour:
- Reset values (asynchronous):
  - halted_o=0, eoc_valid_o=0, exit_code_o=0, narrow_gnt_o=0, narrow_rvalid_o=0, narrow_rdata_o=0, boot_mode_o=0, boot_err_o=0.
  - Memory contents are not reset.
- Boot mode latch:
  - boot_mode_o captures boot_mode_i on the first rising clk_i after rst_ni deasserts, then holds until the next reset.
  - boot_err_o=1 if the captured value is 2'd1.
- Halt/resume:
  - halt_req_i sets halted_o on the next edge; resume_req_i clears it.
  - If both are asserted in the same cycle, halt wins.
  - Halt and resume requests are accepted at any time.
- Arbitration (single bank, combinational grant):
  - narrow_gnt_o[1] = narrow_req_i[1].
  - narrow_gnt_o[0] = narrow_req_i[0] & ~narrow_req_i[1] & ~halted_o.
  - Port 1 (preload) has strict priority; port 0 stalls while the hart is halted.
- Address decode:
  - In memory range when MemBaseAddr <= addr < MemBaseAddr + 4*MemNumWords.
  - Word index = (addr - MemBaseAddr) >> 2; addr[1:0] is ignored.
- Granted write:
  - Bytes with strb set are updated at the grant edge.
  - Unmapped writes are dropped, except a port-0 write to EocAddr.
- Granted read:
  - Returns the old word.
  - Unmapped reads return ErrData.
  - A port-0 read of EocAddr returns {exit_code_o[30:0], eoc_valid_o}.
- Response timing:
  - Every granted request (read or write) produces narrow_rvalid_o[p]=1 exactly one cycle after the grant.
  - narrow_rdata_o[p] is valid in that same cycle and holds its value otherwise.
  - Back-to-back grants yield back-to-back rvalids.
- Same-word conflicts: cannot occur, because the ports are serialized by arbitration.
- EOC register:
  - A port-0 write to EocAddr with wdata[0]=1 sets eoc_valid_o and exit_code_o = {1'b0, wdata[31:1]} on the next edge.
  - eoc_valid_o is sticky until reset.
  - A write with wdata[0]=0 updates nothing.
  - Port 1 cannot write the EOC register; such a write is dropped.
- Reset mid-operation: pending rvalids are cancelled; no write completes after rst_ni falls.

Decomposition:
- chimera_fixture_pkg holds:
  - the address constants (MemBaseAddr, EocAddr, ErrData);
  - the narrow request typedef {req, we, addr, wdata, strb};
  - the narrow response typedef {gnt, rvalid, rdata};
  - the boot-mode enum (IDLE=0, SD=1, SPI=2, I2C=3).
- One natural sub-module: chimera_fixture_sram, a byte-strobed single-port word array with 1-cycle read latency.
- The top module holds arbitration, decode, EOC, halt and boot logic.

Test Plan:
1. Reset check: deassert rst_ni with boot_mode_i=2 -> boot_mode_o=2, boot_err_o=0; every other output reads 0.
2. Preload: pulse halt_req_i, then port-1 writes of 0xDEADBEEF at 0x4800_0000 and 0x1234_5678 at 0x4800_0004, strb=4'hf, on consecutive cycles. Required:
   - gnt[1]=1 in each write cycle and rvalid[1]=1 one cycle later;
   - port-0 reads of both addresses return the written data, after resume.
3. Priority and halt: while halted, port 0 requests continuously -> gnt[0]=0. Pulse resume_req_i -> gnt[0]=1 on the next cycle when port 1 is idle. With simultaneous requests on both ports -> only gnt[1]=1.
4. Strobes and unmapped access:
   - write 0xAABBCCDD with strb=4'b0101 over a word holding 0 -> readback 0x00BB00DD;
   - read 0x5000_0000 -> rdata=0xBADCAB1E with rvalid one cycle later.
5. EOC: port-0 write of 0x0000_0000 to 0x0300_0008 -> eoc_valid_o stays 0. Then write 0x0000_0001 -> eoc_valid_o=1, exit_code_o=0. Write 0x0000_0007 on a fresh run -> exit_code_o=3.
6. Reset mid-operation: assert rst_ni low in the cycle after a grant -> rvalid stays 0; eoc_valid_o=0; boot_mode_o is re-latched after release.
